// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR conversion controller.
//   sar_state_e   : controller FSM state encoding
//   NBITS_DEF     : default conversion resolution
//   SAMPLE_DEF    : default track/sample phase length (clocks)
//   SETTLE_DEF    : default DAC settle time per bit (clocks)
//   CNT_W         : width of the phase timer counter
package sar_pkg;

    localparam int NBITS_DEF  = 10;
    localparam int SAMPLE_DEF = 4;
    localparam int SETTLE_DEF = 1;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        DONE
    } sar_state_e;

endpackage

// File: rtl/sar_phase_timer.sv
// sar_phase_timer: loadable down-counter timing the SAMPLE and SETTLE phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val on this edge (takes priority over counting)
//   load_val   : phase length in clocks (1..15)
//   zero       : this is the last cycle of the loaded duration; the count
//                reaches zero at the coming edge
module sar_phase_timer
    import sar_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    // Flagging one count early lets a phase loaded with N last exactly N clocks.
    assign zero = (cnt <= CNT_W'(1));

endmodule

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation ADC sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : conversion request, honoured only in IDLE
//   comp        : comparator, 1 when Vin >= Vdac(trial)
//   ready       : consumer accepts data while valid is high
//   sample_en   : closes the track switch during SAMPLE
//   dac_code    : trial code to the capacitor DAC
//   bitctrl     : one-hot bit strobe, active only in COMPARE
//   busy        : high in every state except IDLE
//   data, valid : conversion result and its qualifier
// Every output is a flop loaded from the next-state values, so no input
// reaches an output without passing through a register.
module sar_controller
    import sar_pkg::*;
#(
    parameter int NBITS         = NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             comp,
    input  logic             ready,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] bitctrl,
    output logic             busy,
    output logic [NBITS-1:0] data,
    output logic             valid
);

    localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;

    sar_state_e       state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [NBITS-1:0] result, result_n;
    logic [NBITS-1:0] data_n, dac_n, bitctrl_n;
    logic             valid_n;
    logic             tload, tzero;
    logic [CNT_W-1:0] tval;

    sar_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tload),
        .load_val (tval),
        .zero     (tzero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            result    <= '0;
            data      <= '0;
            valid     <= 1'b0;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            dac_code  <= '0;
            bitctrl   <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            result    <= result_n;
            data      <= data_n;
            valid     <= valid_n;
            sample_en <= (state_n == SAMPLE);
            busy      <= (state_n != IDLE);
            dac_code  <= dac_n;
            bitctrl   <= bitctrl_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        result_n = result;
        data_n   = data;
        valid_n  = valid;
        tload    = 1'b0;
        tval     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SAMPLE;
                    tload   = 1'b1;
                    tval    = CNT_W'(SAMPLE_CYCLES);
                end
            end
            SAMPLE: begin
                if (tzero) begin
                    state_n  = SETTLE;
                    ptr_n    = PW'(NBITS - 1);
                    result_n = '0;
                    tload    = 1'b1;
                    tval     = CNT_W'(SETTLE_CYCLES);
                end
            end
            SETTLE: begin
                if (tzero)
                    state_n = COMPARE;
            end
            COMPARE: begin
                result_n[ptr] = comp;
                if (ptr != '0) begin
                    state_n = SETTLE;
                    ptr_n   = ptr - PW'(1);
                    tload   = 1'b1;
                    tval    = CNT_W'(SETTLE_CYCLES);
                end else begin
                    state_n = DONE;
                    data_n  = result_n;
                    valid_n = 1'b1;
                end
            end
            DONE: begin
                if (ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output images of the next state, registered above.
    always_comb begin
        dac_n     = '0;
        bitctrl_n = '0;
        case (state_n)
            SETTLE:  dac_n = result_n | (NBITS'(1) << ptr_n);
            COMPARE: begin
                dac_n     = result_n | (NBITS'(1) << ptr_n);
                bitctrl_n = NBITS'(1) << ptr_n;
            end
            DONE:    dac_n = data_n;
            default: dac_n = '0;
        endcase
    end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 SHALL have parameter NBITS, default 10, giving conversion resolution and the widths of bitctrl, dac_code and data.
REQ-002 SHALL have parameter SAMPLE_CYCLES, default 4, giving track/sample phase length in clocks (legal range 1..15).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1, giving DAC settle time per bit before comparison (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, conversion request; sampled only in IDLE.
REQ-007 SHALL have port comp, input, 1, comparator result; 1 means Vin >= Vdac(trial).
REQ-008 SHALL have port sample_en, output, 1, which closes the track switch.
REQ-009 SHALL have port dac_code, output, NBITS, the trial code driven to the capacitor DAC.
REQ-010 SHALL have port bitctrl, output, NBITS, a one-hot bit strobe that feeds the 1-to-NBITS bit demultiplexer.
REQ-011 SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-012 SHALL have port data, output, NBITS, the conversion result.
REQ-013 SHALL have port valid, output, 1, meaning data is valid.
REQ-014 SHALL have port ready, input, 1, the consumer's acceptance of data.

Function
REQ-015 SHALL implement FSM states IDLE, SAMPLE, SETTLE, COMPARE and DONE.
REQ-016 IDLE with start=1 SHALL go to SAMPLE and load a cycle counter with SAMPLE_CYCLES; start=0 SHALL stay in IDLE.
REQ-017 SAMPLE SHALL hold sample_en=1 for exactly SAMPLE_CYCLES clocks and then go to SETTLE with bit pointer = NBITS-1 and result register = 0.
REQ-018 SETTLE SHALL drive dac_code = result | (1<<ptr), hold for SETTLE_CYCLES clocks, and then go to COMPARE.
REQ-019 COMPARE SHALL keep the same dac_code for one clock with bitctrl = (1<<ptr), and bitctrl SHALL be 0 in every other state.
REQ-020 At the COMPARE edge, result[ptr] SHALL take comp; if ptr>0, ptr SHALL decrement and the FSM SHALL go to SETTLE; if ptr=0, the FSM SHALL go to DONE with data = final result and valid=1.
REQ-021 The valid rising edge SHALL occur SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1) edges after the edge that sampled start (24 at defaults).
REQ-022 In DONE, valid and data SHALL hold stable until ready=1; the valid&&ready edge SHALL clear valid and return the FSM to IDLE.
REQ-023 ready SHALL be ignored when valid=0; a ready already high when DONE is entered SHALL complete the handshake on the first DONE edge.
REQ-024 start SHALL be ignored in SAMPLE, SETTLE, COMPARE and DONE, with no queued request.
REQ-025 start asserted on the same edge as the DONE-to-IDLE transition SHALL be ignored; it SHALL be honoured on the next edge if it is still high.
REQ-026 dac_code SHALL be 0 in IDLE and SAMPLE, and SHALL equal data in DONE.
REQ-027 data SHALL update only on entry to DONE and SHALL otherwise retain the last result.
REQ-028 All outputs SHALL be registered, with no combinational path from comp, start or ready to any output.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and set sample_en=0, dac_code=0, bitctrl=0, busy=0, valid=0, data=0, and clear ptr, counter and result.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse; the first start after deassertion SHALL begin a fresh conversion.
REQ-031 Reset deassertion SHALL be treated as synchronous to clk by the integrating level, so no internal synchroniser is required.

Structure
REQ-032 Shared package sar_pkg SHALL hold the state enum type, the default NBITS/SAMPLE_CYCLES/SETTLE_CYCLES constants, and the counter width constant (4 bits).
REQ-033 There SHALL be one sub-module, sar_phase_timer: a loadable 4-bit down-counter with a load input, a load value and a zero flag, used for both the SAMPLE and SETTLE durations.

Verification
REQ-034 comp tied 1, one start pulse -> data=0x3FF, valid high 24 edges after start, and bitctrl sequence 0x200,0x100,...,0x001, one strobe per COMPARE.
REQ-035 Behavioural comparator comp=(vin>=dac_code) with vin=0x2AA -> data=0x2AA; repeat with vin=0x000 -> data=0x000, and with vin=0x3FF -> data=0x3FF.
REQ-036 ready held 0 for 10 clocks after valid -> valid and data stable throughout; ready=1 -> valid drops on the next edge and busy=0.
REQ-037 start pulsed during bit 5 of a conversion -> no effect: exactly one valid, and the result matches the first request.
REQ-038 rst_n pulsed low during COMPARE of bit 3 -> all outputs 0 immediately and no valid; a subsequent start with vin=0x155 -> data=0x155.
